fp_mult: RTL and testbench

FP_MULT -- requirements
Module: fp_mult

---
 rtl/fp_mult_if.sv | 34 +++
 rtl/fp_mult.sv | 240 ++++++++++++++++++++++++
 tb/tb_fp_mult.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fp_mult_if.sv
// fp_mult_if -- operand/result bundle for the binary32 multiplier.
//
// Signals:
//   input_a, input_b : binary32 operands (driven by the requester)
//   en               : start request, level-sensitive
//   done             : result-valid flag (driven by the multiplier)
//   output_z         : binary32 product (driven by the multiplier)
//
// Modports:
//   master : requester side (drives operands and en, observes result)
//   slave  : multiplier side
interface fp_mult_if;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        en;
  logic        done;
  logic [31:0] output_z;

  modport master (
    output input_a,
    output input_b,
    output en,
    input  done,
    input  output_z
  );

  modport slave (
    input  input_a,
    input  input_b,
    input  en,
    output done,
    output output_z
  );
endinterface

// File: rtl/fp_mult.sv
// fp_mult -- multi-cycle IEEE-754 binary32 multiplier, round-to-nearest-even.
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset; forces IDLE and clears done,
//          leaves output_z untouched
//   bus  : fp_mult_if.slave -- input_a/input_b/en in, done/output_z out
//
// Operation: en high in IDLE latches both operands. The FSM unpacks them,
// resolves NaN/Inf/zero operands directly, otherwise normalises denormal
// inputs, multiplies the 24-bit mantissas, renormalises (left for normal
// results, right for denormal results), rounds RNE and packs. The result
// then sits in DONE with done=1 until rst. Normal operands with a normal
// result take 11 edges from the en edge to done; the special path takes 3.
module fp_mult (
  input  logic       clk,
  input  logic       rst,
  fp_mult_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULT0, MULT1,
    NORM1, NORM2, ROUND, PACK, DONE
  } state_t;

  // Unbiased exponent limits; exponents carry 10 signed bits so that the
  // sum of two denormal-normalised exponents and overflow cases never wrap.
  localparam logic signed [9:0] E_MIN    = -10'sd126;
  localparam logic signed [9:0] E_MIN_M1 = -10'sd127;
  localparam logic signed [9:0] E_MIN_P1 = -10'sd125;
  localparam logic signed [9:0] E_MAX    =  10'sd127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Power-up values make the block usable before the first reset pulse.
  state_t      state = IDLE;
  state_t      state_nxt;
  logic        done_q = 1'b0;
  logic [31:0] z_q    = 32'h0000_0000;

  // Datapath registers (no reset: their contents are only meaningful once
  // the FSM has walked through the states that load them).
  logic [31:0]        a_q, b_q;
  logic signed [9:0]  a_e, b_e, z_e;
  logic [23:0]        a_m, b_m, z_m;
  logic [47:0]        prod;
  logic               z_s;
  logic               guard, rnd, sticky;

  // Operand classification, taken straight from the latched words.
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
  logic special_hit;
  logic res_sign;
  logic [31:0] special_z;
  logic [31:0] pack_z;
  logic [7:0]  pack_exp;

  function automatic logic signed [9:0] exp_unbias(input logic [7:0] field);
    if (field == 8'd0)
      return E_MIN;
    else
      return $signed({2'b00, field}) - 10'sd127;
  endfunction

  // RNE: round up when above the halfway point, or exactly halfway with an
  // odd lsb.
  function automatic logic round_up(input logic g, input logic r,
                                    input logic s, input logic lsb);
    return g & (r | s | lsb);
  endfunction

  always_comb begin
    a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
    a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    a_zero = ~(|a_q[30:0]);
    b_zero = ~(|b_q[30:0]);
    a_den  = ~(|a_q[30:23]) & (|a_q[22:0]);
    b_den  = ~(|b_q[30:23]) & (|b_q[22:0]);
    res_sign = a_q[31] ^ b_q[31];

    // Two denormals multiply to below 2^-252, which always rounds to zero;
    // resolving it here bounds the worst-case latency.
    special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero |
                  (a_den & b_den);

    if (a_nan | b_nan)
      special_z = QNAN;
    else if ((a_inf & b_zero) | (b_inf & a_zero))
      special_z = QNAN;
    else if (a_inf | b_inf)
      special_z = {res_sign, 8'hFF, 23'd0};
    else
      special_z = {res_sign, 31'd0};
  end

  always_comb begin
    pack_exp = 8'(z_e + 10'sd127);
    if (z_e > E_MAX)
      pack_z = {z_s, 8'hFF, 23'd0};
    else if ((z_e == E_MIN) && !z_m[23])
      pack_z = {z_s, 8'h00, z_m[22:0]};
    else
      pack_z = {z_s, pack_exp, z_m[22:0]};
  end

  // Next-state logic. The shift loops look one step ahead so that the
  // cycle performing the final shift also leaves the state; this keeps a
  // single-shift renormalisation inside the 11-edge normal latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = special_hit ? DONE : NORM_A;
      NORM_A:  if (a_m[23] || a_m[22]) state_nxt = NORM_B;
      NORM_B:  if (b_m[23] || b_m[22]) state_nxt = MULT0;
      MULT0:   state_nxt = MULT1;
      MULT1:   state_nxt = NORM1;
      NORM1: begin
        if (z_m[23] || z_m[22] || (z_e <= E_MIN_P1))
          state_nxt = NORM2;
      end
      NORM2: begin
        if ((z_e >= E_MIN_M1) || (~(|z_m) && !guard && !rnd))
          state_nxt = ROUND;
      end
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.en) begin
          a_q <= bus.input_a;
          b_q <= bus.input_b;
        end
      end
      // --- unpack: sign, unbiased exponent, mantissa with hidden bit
      UNPACK: begin
        a_m <= {|a_q[30:23], a_q[22:0]};
        b_m <= {|b_q[30:23], b_q[22:0]};
        a_e <= exp_unbias(a_q[30:23]);
        b_e <= exp_unbias(b_q[30:23]);
        z_s <= a_q[31] ^ b_q[31];
      end
      // --- normalise denormal inputs until the hidden bit is set
      NORM_A: begin
        if (!a_m[23]) begin
          a_m <= {a_m[22:0], 1'b0};
          a_e <= a_e - 10'sd1;
        end
      end
      NORM_B: begin
        if (!b_m[23]) begin
          b_m <= {b_m[22:0], 1'b0};
          b_e <= b_e - 10'sd1;
        end
      end
      // --- multiply: product of two 1.x mantissas lies in [1,4); taking
      // the top 24 bits reads it as 0.1x, hence the +1 on the exponent
      MULT0: begin
        prod <= {24'd0, a_m} * {24'd0, b_m};
        z_e  <= a_e + b_e + 10'sd1;
      end
      MULT1: begin
        z_m    <= prod[47:24];
        guard  <= prod[23];
        rnd    <= prod[22];
        sticky <= |prod[21:0];
      end
      // --- renormalise left for normal results
      NORM1: begin
        if (!z_m[23] && (z_e > E_MIN)) begin
          z_m   <= {z_m[22:0], guard};
          guard <= rnd;
          rnd   <= 1'b0;
          z_e   <= z_e - 10'sd1;
        end
      end
      // --- shift right into the denormal range, folding lost bits into
      // sticky; once every kept bit is zero further shifts change nothing
      // but the exponent, so jump straight to the minimum
      NORM2: begin
        if (z_e < E_MIN) begin
          if (~(|z_m) && !guard && !rnd) begin
            z_e <= E_MIN;
          end else begin
            z_e    <= z_e + 10'sd1;
            z_m    <= {1'b0, z_m[23:1]};
            guard  <= z_m[0];
            rnd    <= guard;
            sticky <= sticky | rnd;
          end
        end
      end
      // --- round to nearest even; an all-ones mantissa carries into the
      // exponent
      ROUND: begin
        if (round_up(guard, rnd, sticky, z_m[0])) begin
          if (&z_m) begin
            z_m <= 24'h80_0000;
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= z_m + 24'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Result register: written only by the special path or PACK. Reset never
  // touches it, so a result stays visible across rst.
  always_ff @(posedge clk) begin
    if ((state == SPECIAL) && special_hit)
      z_q <= special_z;
    else if (state == PACK)
      z_q <= pack_z;
  end

  assign bus.done     = done_q;
  assign bus.output_z = z_q;

endmodule

// File: tb/tb_fp_mult.sv
// tb_fp_mult -- directed self-checking bench for fp_mult.
module tb_fp_mult;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fp_mult_if bus ();

  fp_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] b2b_a [4] = '{32'h4000_0000, 32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FC0_0001};
  logic [31:0] b2b_b [4] = '{32'h4040_0000, 32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FC0_0001};
  logic [31:0] b2b_z [4] = '{32'h40C0_0000, 32'h3F80_0002, 32'h407F_FFFE, 32'h4010_0002};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with rst low. Drives operands and en, then
  // counts edges until done. exp_lat=0 means only the 80-edge bound applies.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z, input int exp_lat, input bit keep_en);
    int n;
    bit seen;
    bus.input_a = a;
    bus.input_b = b;
    bus.en      = 1'b1;
    @(posedge clk);
    #1;
    n    = 1;
    seen = bus.done;
    if (!keep_en) bus.en = 1'b0;
    // operands are free to change once latched
    bus.input_a = $urandom;
    bus.input_b = $urandom;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.done;
    end
    if (exp_lat > 0)
      check({tag, " latency"}, n, exp_lat);
    else
      check({tag, " latency bound"}, {31'd0, (seen && n <= 80)}, 32'd1);
    check({tag, " result"}, bus.output_z, exp_z);
    @(negedge clk);
  endtask

  // Called just after a negedge; leaves rst low right after a negedge.
  task automatic do_reset(input int cycles, input logic [31:0] held_z);
    rst = 1'b1;
    #1;
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset keeps z", bus.output_z, held_z);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.input_a = 32'h0;
    bus.input_b = 32'h0;
    bus.en      = 1'b0;
    #1;
    check("power-up done", {31'd0, bus.done}, 32'd0);
    check("power-up z", bus.output_z, 32'h0);

    // idle with en low: nothing happens
    repeat (3) @(negedge clk);
    check("idle done", {31'd0, bus.done}, 32'd0);
    check("idle z", bus.output_z, 32'h0);

    // normal multiply before any reset pulse: 2 * 3 = 6
    run_op("2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 11, 1'b0);

    // DONE holds with en high and new operands offered
    bus.en      = 1'b1;
    bus.input_a = 32'h3F80_0000;
    bus.input_b = 32'h3F80_0000;
    repeat (20) @(posedge clk);
    #1;
    check("hold done", {31'd0, bus.done}, 32'd1);
    check("hold z", bus.output_z, 32'h40C0_0000);
    @(negedge clk);
    bus.en = 1'b0;
    do_reset(2, 32'h40C0_0000);

    // signed multiply: 1.5 * -2.5 = -3.75, then a 2-cycle reset
    run_op("signed", 32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, 11, 1'b0);
    do_reset(2, 32'hC070_0000);
    repeat (2) @(negedge clk);
    check("post-reset done", {31'd0, bus.done}, 32'd0);
    check("post-reset z", bus.output_z, 32'hC070_0000);

    // special operands
    run_op("inf*0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3, 1'b0);
    do_reset(1, 32'h7FC0_0000);
    run_op("-inf*2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3, 1'b0);
    do_reset(1, 32'hFF80_0000);
    run_op("-0*1", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3, 1'b0);
    do_reset(1, 32'h8000_0000);
    run_op("nan*1", 32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3, 1'b0);
    do_reset(1, 32'h7FC0_0000);

    // overflow and underflow
    run_op("overflow", 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 11, 1'b0);
    do_reset(1, 32'h7F80_0000);
    run_op("to-denormal", 32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 11, 1'b0);
    do_reset(1, 32'h0040_0000);
    run_op("tie-to-zero", 32'h0000_0001, 32'h3F00_0000, 32'h0000_0000, 0, 1'b0);
    do_reset(1, 32'h0000_0000);

    // reset in the middle of an operation
    bus.input_a = 32'h4000_0000;
    bus.input_b = 32'h4040_0000;
    bus.en      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.en = 1'b0;
    rst    = 1'b1;
    #1;
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort state", 32'(dut.state), 32'd0);
    check("abort keeps z", bus.output_z, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op("1x10", 32'h3F80_0000, 32'h4120_0000, 32'h4120_0000, 11, 1'b0);

    // back-to-back with en held high through done and reset
    bus.en = 1'b1;
    do_reset(2, 32'h4120_0000);
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("b2b%0d", i), b2b_a[i], b2b_b[i], b2b_z[i], 11, 1'b1);
      do_reset(2, b2b_z[i]);
    end
    bus.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
